// File: rtl/digit_pkg.sv
// Shared constants and state encoding for the keypad-style digit packer.
package digit_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int DIGIT_W    = 4;
  localparam int ENTRY_W    = NUM_DIGITS * DIGIT_W;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_ENTRY  = 2'd1,
    ST_FULL   = 2'd2,
    ST_OUTPUT = 2'd3
  } state_t;

endpackage

// File: rtl/digit_packer.sv
// Collects up to four digits into a right-aligned 16-bit entry, supports
// backspace/clear, and publishes the entry through a valid/ready port.
//
//   state     | meaning
//   ST_EMPTY  | no digits held, accepting digits
//   ST_ENTRY  | 1..3 digits held, accepting digits
//   ST_FULL   | 4 digits held, waiting for commit/backspace/clear
//   ST_OUTPUT | committed number presented on out_number
module digit_packer
  import digit_pkg::*;
#(
  parameter bit DECIMAL     = 1'b1,
  parameter bit AUTO_COMMIT = 1'b0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               digit_valid,
  input  logic [DIGIT_W-1:0] digit,
  output logic               digit_ready,
  input  logic               backspace,
  input  logic               clear,
  input  logic               commit,
  output logic [ENTRY_W-1:0] entry_value,
  output logic [2:0]         count,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ENTRY_W-1:0] out_number,
  output logic               err
);

  localparam logic [2:0] LAST_SLOT = 3'(NUM_DIGITS - 1);

  state_t             state, state_nxt;
  logic [ENTRY_W-1:0] entry_nxt, out_number_nxt, shifted_in;
  logic [2:0]         count_nxt;
  logic               out_valid_nxt, err_nxt, ready_nxt;
  logic               accept, bad_digit;

  assign accept     = digit_valid && digit_ready;
  assign bad_digit  = DECIMAL && (digit > 4'd9);
  assign shifted_in = {entry_value[ENTRY_W-DIGIT_W-1:0], digit};

  // Next-state decode; the if/else order sets clear > backspace > commit > digit.
  always_comb begin
    state_nxt      = state;
    entry_nxt      = entry_value;
    count_nxt      = count;
    out_valid_nxt  = out_valid;
    out_number_nxt = out_number;
    err_nxt        = 1'b0;

    if (clear) begin
      state_nxt     = ST_EMPTY;
      entry_nxt     = '0;
      count_nxt     = 3'd0;
      out_valid_nxt = 1'b0;
    end else if (state == ST_OUTPUT) begin
      if (out_valid && out_ready) begin
        state_nxt     = ST_EMPTY;
        entry_nxt     = '0;
        count_nxt     = 3'd0;
        out_valid_nxt = 1'b0;
      end
    end else if (backspace) begin
      if (state != ST_EMPTY) begin
        entry_nxt = {{DIGIT_W{1'b0}}, entry_value[ENTRY_W-1:DIGIT_W]};
        count_nxt = count - 3'd1;
        state_nxt = (count == 3'd1) ? ST_EMPTY : ST_ENTRY;
      end
    end else if (commit) begin
      if (state != ST_EMPTY) begin
        out_number_nxt = entry_value;
        out_valid_nxt  = 1'b1;
        state_nxt      = ST_OUTPUT;
      end
    end else if (accept) begin
      if (bad_digit) begin
        err_nxt = 1'b1;
      end else begin
        entry_nxt = shifted_in;
        count_nxt = count + 3'd1;
        if (count == LAST_SLOT) begin
          if (AUTO_COMMIT) begin
            out_number_nxt = shifted_in;
            out_valid_nxt  = 1'b1;
            state_nxt      = ST_OUTPUT;
          end else begin
            state_nxt = ST_FULL;
          end
        end else begin
          state_nxt = ST_ENTRY;
        end
      end
    end

    // Ready is registered from the next state so it stays a pure state decode.
    ready_nxt = (state_nxt == ST_EMPTY) || (state_nxt == ST_ENTRY);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_EMPTY;
      entry_value <= '0;
      count       <= 3'd0;
      out_valid   <= 1'b0;
      out_number  <= '0;
      err         <= 1'b0;
      digit_ready <= 1'b1;
    end else begin
      state       <= state_nxt;
      entry_value <= entry_nxt;
      count       <= count_nxt;
      out_valid   <= out_valid_nxt;
      out_number  <= out_number_nxt;
      err         <= err_nxt;
      digit_ready <= ready_nxt;
    end
  end

endmodule

// File: tb/tb_digit_packer.sv
// Directed bench for digit_packer: default configuration (dut0) and an
// AUTO_COMMIT=1, DECIMAL=0 configuration (dut1). Committed numbers are
// checked by a scoreboard queue per instance.
module tb_digit_packer;

  logic clk;
  logic reset_n;

  logic        dv0, bs0, clr0, cm0, ordy0;
  logic [3:0]  dg0;
  logic        drdy0, ov0, err0;
  logic [15:0] ev0, on0;
  logic [2:0]  cnt0;

  logic        dv1, bs1, clr1, cm1, ordy1;
  logic [3:0]  dg1;
  logic        drdy1, ov1, err1;
  logic [15:0] ev1, on1;
  logic [2:0]  cnt1;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] q0[$];
  logic [15:0] q1[$];

  digit_packer #(.DECIMAL(1'b1), .AUTO_COMMIT(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n), .digit_valid(dv0), .digit(dg0),
    .digit_ready(drdy0), .backspace(bs0), .clear(clr0), .commit(cm0),
    .entry_value(ev0), .count(cnt0), .out_valid(ov0), .out_ready(ordy0),
    .out_number(on0), .err(err0)
  );

  digit_packer #(.DECIMAL(1'b0), .AUTO_COMMIT(1'b1)) dut1 (
    .clk(clk), .reset_n(reset_n), .digit_valid(dv1), .digit(dg1),
    .digit_ready(drdy1), .backspace(bs1), .clear(clr1), .commit(cm1),
    .entry_value(ev1), .count(cnt1), .out_valid(ov1), .out_ready(ordy1),
    .out_number(on1), .err(err1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitors: pop on every output handshake.
  always @(negedge clk) begin
    if (reset_n && ov0 && ordy0) begin
      if (q0.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL out0_unexpected: got 0x%0h, expected no output", on0);
      end else begin
        chk("out0_number", on0, q0.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n && ov1 && ordy1) begin
      if (q1.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL out1_unexpected: got 0x%0h, expected no output", on1);
      end else begin
        chk("out1_number", on1, q1.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic digit0(input logic [3:0] d);
    dv0 = 1'b1; dg0 = d;
    tick();
    dv0 = 1'b0; dg0 = 4'h0;
  endtask

  task automatic digit1(input logic [3:0] d);
    dv1 = 1'b1; dg1 = d;
    tick();
    dv1 = 1'b0; dg1 = 4'h0;
  endtask

  task automatic pulse0(input logic b, input logic c, input logic m);
    bs0 = b; clr0 = c; cm0 = m;
    tick();
    bs0 = 1'b0; clr0 = 1'b0; cm0 = 1'b0;
  endtask

  task automatic consume0();
    ordy0 = 1'b1;
    tick();
    ordy0 = 1'b0;
  endtask

  initial begin
    dv0 = 0; bs0 = 0; clr0 = 0; cm0 = 0; ordy0 = 0; dg0 = 4'h0;
    dv1 = 0; bs1 = 0; clr1 = 0; cm1 = 0; ordy1 = 0; dg1 = 4'h0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #12;
    chk("rst_entry", ev0, 16'h0000);
    chk("rst_count", 16'(cnt0), 16'd0);
    chk("rst_out_valid", 16'(ov0), 16'd0);
    chk("rst_out_number", on0, 16'h0000);
    chk("rst_err", 16'(err0), 16'd0);
    reset_n = 1'b1;
    tick();
    chk("idle_ready", 16'(drdy0), 16'd1);

    // 1,2,3,4 then commit
    digit0(4'd1); digit0(4'd2);
    chk("two_digits", ev0, 16'h0012);
    digit0(4'd3); digit0(4'd4);
    chk("full_entry", ev0, 16'h1234);
    chk("full_count", 16'(cnt0), 16'd4);
    chk("full_ready", 16'(drdy0), 16'd0);
    digit0(4'd5);
    chk("fifth_entry", ev0, 16'h1234);
    chk("fifth_count", 16'(cnt0), 16'd4);
    q0.push_back(16'h1234);
    pulse0(1'b0, 1'b0, 1'b1);
    chk("commit_valid", 16'(ov0), 16'd1);
    chk("commit_number", on0, 16'h1234);
    digit0(4'd6);
    chk("output_ignores_digit", ev0, 16'h1234);
    chk("output_holds_valid", 16'(ov0), 16'd1);
    consume0();
    chk("drain_valid", 16'(ov0), 16'd0);
    chk("drain_entry", ev0, 16'h0000);
    chk("drain_count", 16'(cnt0), 16'd0);
    chk("drain_ready", 16'(drdy0), 16'd1);

    // 7,5, backspace, 9, commit
    digit0(4'd7); digit0(4'd5);
    pulse0(1'b1, 1'b0, 1'b0);
    chk("bs_entry", ev0, 16'h0007);
    chk("bs_count", 16'(cnt0), 16'd1);
    digit0(4'd9);
    q0.push_back(16'h0079);
    pulse0(1'b0, 1'b0, 1'b1);
    chk("commit79", on0, 16'h0079);
    consume0();
    pulse0(1'b1, 1'b0, 1'b0);
    chk("bs_empty_entry", ev0, 16'h0000);
    chk("bs_empty_count", 16'(cnt0), 16'd0);
    pulse0(1'b0, 1'b0, 1'b1);
    chk("commit_empty_ignored", 16'(ov0), 16'd0);

    // non-BCD rejection
    digit0(4'd3);
    digit0(4'hA);
    chk("bad_err", 16'(err0), 16'd1);
    chk("bad_entry", ev0, 16'h0003);
    chk("bad_count", 16'(cnt0), 16'd1);
    tick();
    chk("bad_err_pulse", 16'(err0), 16'd0);
    pulse0(1'b0, 1'b1, 1'b0);
    chk("clear_entry", ev0, 16'h0000);

    // backspace from FULL returns to ENTRY
    digit0(4'd1); digit0(4'd2); digit0(4'd3); digit0(4'd4);
    pulse0(1'b1, 1'b0, 1'b0);
    chk("full_bs_entry", ev0, 16'h0123);
    chk("full_bs_count", 16'(cnt0), 16'd3);
    chk("full_bs_ready", 16'(drdy0), 16'd1);
    pulse0(1'b0, 1'b1, 1'b0);

    // clear + backspace + commit together
    digit0(4'd1); digit0(4'd2);
    chk("pre_combo", ev0, 16'h0012);
    pulse0(1'b1, 1'b1, 1'b1);
    chk("combo_entry", ev0, 16'h0000);
    chk("combo_count", 16'(cnt0), 16'd0);
    chk("combo_valid", 16'(ov0), 16'd0);
    tick();
    chk("combo_valid_later", 16'(ov0), 16'd0);

    // reset while presenting output, no out_ready
    digit0(4'd5);
    pulse0(1'b0, 1'b0, 1'b1);
    chk("pre_rst_valid", 16'(ov0), 16'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_valid", 16'(ov0), 16'd0);
    chk("async_rst_count", 16'(cnt0), 16'd0);
    #3 reset_n = 1'b1;
    tick();

    // auto-commit instance
    digit1(4'd4); digit1(4'd3); digit1(4'd2);
    chk("auto_partial_valid", 16'(ov1), 16'd0);
    q1.push_back(16'h4321);
    digit1(4'd1);
    chk("auto_valid", 16'(ov1), 16'd1);
    chk("auto_number", on1, 16'h4321);
    chk("auto_ready", 16'(drdy1), 16'd0);
    ordy1 = 1'b1; tick(); ordy1 = 1'b0;
    chk("auto_drain", 16'(ov1), 16'd0);
    q1.push_back(16'hF0A5);
    digit1(4'hF); digit1(4'h0); digit1(4'hA);
    chk("hex_err", 16'(err1), 16'd0);
    digit1(4'h5);
    chk("hex_number", on1, 16'hF0A5);
    ordy1 = 1'b1; tick(); ordy1 = 1'b0;
    tick();

    chk("q0_empty", 16'(q0.size()), 16'd0);
    chk("q1_empty", 16'(q1.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/digit_packer.md
DIGIT_PACKER -- requirements
Module: digit_packer

Interface
REQ-001 Parameter: DECIMAL, default 1, when 1 digits >9 are rejected as non-BCD; when 0 all 16 hex values are legal.
REQ-002 Parameter: AUTO_COMMIT, default 0, when 1 acceptance of the 4th digit commits automatically.
REQ-003 Clocking: one clock; reset is asynchronous and active-low.
REQ-004 Port: clk  input  1  rising-edge clock for all state.
REQ-005 Port: reset_n  input  1  asynchronous active-low reset.
REQ-006 Port: digit_valid  input  1  digit offered this cycle.
REQ-007 Port: digit  input  4  offered digit value.
REQ-008 Port: digit_ready  output  1  packer can accept a digit this cycle.
REQ-009 Port: backspace  input  1  single-cycle request to remove the last entered digit.
REQ-010 Port: clear  input  1  single-cycle request to discard the entry.
REQ-011 Port: commit  input  1  single-cycle request to publish the entry.
REQ-012 Port: entry_value  output  16  live right-aligned entry; ones in [3:0], thousands in [15:12].
REQ-013 Port: count  output  3  digits currently held, 0..4.
REQ-014 Port: out_valid  output  1  committed number available.
REQ-015 Port: out_ready  input  1  consumer takes committed number.
REQ-016 Port: out_number  output  16  committed number, stable while out_valid is high.
REQ-017 Port: err  output  1  one-cycle pulse on a rejected non-BCD digit.

Function
REQ-018 States SHALL be EMPTY (count=0), ENTRY (count 1..3), FULL (count=4) and OUTPUT (out_valid=1).
REQ-019 digit_ready SHALL be 1 in EMPTY and ENTRY and 0 in FULL and OUTPUT; it SHALL depend only on state.
REQ-020 A digit is accepted when digit_valid && digit_ready; entry_value becomes {entry_value[11:0], digit} and count increments, both visible the next cycle.
REQ-021 With DECIMAL=1, a handshaken digit >9 SHALL be discarded, leave entry_value/count unchanged and pulse err on the next cycle.
REQ-022 backspace in ENTRY/FULL: entry_value shifts right 4 with zero fill and count decrements; EMPTY->no-op; FULL->ENTRY, count 1->EMPTY.
REQ-023 commit in ENTRY/FULL: out_number <= entry_value, out_valid rises the next cycle, state OUTPUT; commit in EMPTY is ignored.
REQ-024 With AUTO_COMMIT=1, accepting the 4th digit SHALL go directly to OUTPUT with out_number equal to the 4-digit value.
REQ-025 In OUTPUT, digit, backspace and commit SHALL be ignored; on out_valid && out_ready, entry_value, count and out_valid clear the next cycle and state returns to EMPTY.
REQ-026 clear in any state SHALL next cycle zero entry_value, count and out_valid and enter EMPTY.
REQ-027 Simultaneous-event priority: clear > backspace > commit > digit acceptance; a lower-priority request in the same cycle is dropped and digit_ready's handshake is still consumed.
REQ-028 All outputs SHALL be registered; no combinational path from any input to any output.

Reset
REQ-029 reset_n low SHALL immediately force EMPTY, entry_value=0, count=0, out_number=0, out_valid=0, err=0; digit_ready=1 while reset is deasserted in EMPTY.
REQ-030 Reset asserted during OUTPUT SHALL drop out_valid without requiring out_ready.

Structure
REQ-031 Package digit_pkg SHALL hold the state enum, NUM_DIGITS=4 and DIGIT_W=4.
REQ-032 No sub-module; the nibble shift register, counter and FSM SHALL be inline in digit_packer.

Verification
REQ-033 Digits 1,2,3,4 then commit -> entry_value 0x1234, count 4, out_valid with out_number 0x1234; out_ready -> EMPTY, entry_value 0.
REQ-034 Digits 7,5, backspace, 9, commit -> out_number 0x0079; backspace in EMPTY -> no change.
REQ-035 DECIMAL=1, digit 0xA offered after 3 -> err one-cycle pulse, entry_value stays 0x0003, count 1.
REQ-036 Four digits held (FULL), fifth digit offered -> digit_ready 0, entry_value unchanged; AUTO_COMMIT=1 with 4,3,2,1 -> out_valid without commit, out_number 0x4321.
REQ-037 clear, backspace and commit in the same cycle with 0x0012 held -> EMPTY, out_valid stays 0.
REQ-038 reset_n asserted while out_valid=1 and out_ready=0 -> out_valid 0 and count 0 immediately, before the next clk edge.
